// File: rtl/arbiter_rr_weighted_if.sv
// Handshake bundle between requesters and the weighted round-robin arbiter.
// master: drives enable/req/req_last/weight/ready_in; slave: drives grant/select/valid.
interface arbiter_rr_weighted_if #(
  parameter int NUM_REQ      = 4,
  parameter int SELECT_WIDTH = $clog2(NUM_REQ),
  parameter int WEIGHT_WIDTH = 4
);
  logic                            enable;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ*WEIGHT_WIDTH-1:0] weight;
  logic                            ready_in;
  logic [NUM_REQ-1:0]              grant;
  logic [SELECT_WIDTH-1:0]         select;
  logic                            valid;

  modport master (
    output enable,
    output req,
    output req_last,
    output weight,
    output ready_in,
    input  grant,
    input  select,
    input  valid
  );

  modport slave (
    input  enable,
    input  req,
    input  req_last,
    input  weight,
    input  ready_in,
    output grant,
    output select,
    output valid
  );
endinterface

// File: rtl/arbiter_rr_weighted.sv
// Weighted round-robin arbiter: IDLE/HOLD FSM, one-hot registered grant.
// Ports: ap_clk, areset (sync, active-high), bus (slave modport of
// arbiter_rr_weighted_if: enable, req, req_last, weight, ready_in in;
// grant, select, valid out). Macro ARBITER_RR_WEIGHTED_EN enables
// weighted credits; without it every tenure lasts one last beat.
module arbiter_rr_weighted #(
  parameter int NUM_REQ      = 4,
  parameter int SELECT_WIDTH = $clog2(NUM_REQ),
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  arbiter_rr_weighted_if.slave  bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [SELECT_WIDTH:0] NREQ_W =
    (SELECT_WIDTH+1)'(NUM_REQ);
  localparam logic [SELECT_WIDTH-1:0] LAST_IDX =
    SELECT_WIDTH'(NUM_REQ-1);
  localparam logic [WEIGHT_WIDTH-1:0] ONE_CRED =
    WEIGHT_WIDTH'(1);

  state_t                  state_q;
  state_t                  state_d;
  logic [SELECT_WIDTH-1:0] ptr_q;
  logic [SELECT_WIDTH-1:0] ptr_d;
  logic [SELECT_WIDTH-1:0] win_q;
  logic [SELECT_WIDTH-1:0] win_d;
  logic [WEIGHT_WIDTH-1:0] cred_q;
  logic [WEIGHT_WIDTH-1:0] cred_d;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REQ-1:0]      grant_d;
  logic [SELECT_WIDTH-1:0] select_q;
  logic [SELECT_WIDTH-1:0] select_d;
  logic                    valid_q;
  logic                    valid_d;

  logic                    pick_found;
  logic [SELECT_WIDTH-1:0] pick_idx;
  logic [SELECT_WIDTH:0]   cand;
  logic [WEIGHT_WIDTH-1:0] cred_load;
  logic [SELECT_WIDTH-1:0] ptr_inc;
  logic                    win_req;
  logic                    win_last;
  logic                    last_beat;

  // Rotating priority scan: first set req at or above ptr_q, wrapping.
  // The extra bit on cand keeps the wrap compare correct for any NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (SELECT_WIDTH+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_found && bus.req[cand[SELECT_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[SELECT_WIDTH-1:0];
      end
    end
  end

`ifdef ARBITER_RR_WEIGHTED_EN
  logic [WEIGHT_WIDTH-1:0] pick_weight;

  always_comb begin
    pick_weight = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (SELECT_WIDTH'(j) == pick_idx) begin
        pick_weight = bus.weight[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  // A zero weight still buys one transaction.
  assign cred_load = (pick_weight == '0) ? ONE_CRED : pick_weight;
`else
  logic unused_weight;

  assign unused_weight = ^bus.weight;
  assign cred_load     = ONE_CRED;
`endif

  assign ptr_inc   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
  assign win_req   = bus.req[win_q];
  assign win_last  = bus.req_last[win_q];
  assign last_beat = win_req && bus.ready_in && win_last;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cred_d  = cred_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && pick_found) begin
          state_d = HOLD;
          win_d   = pick_idx;
          cred_d  = cred_load;
        end
      end
      HOLD: begin
        if (!win_req) begin
          state_d = IDLE;
          ptr_d   = ptr_inc;
          cred_d  = '0;
        end else if (last_beat) begin
          cred_d = cred_q - 1'b1;
          if (cred_q <= ONE_CRED) begin
            state_d = IDLE;
            ptr_d   = ptr_inc;
            cred_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view, so the grant
  // appears the cycle after the pick and drops the cycle after release.
  always_comb begin
    valid_d  = (state_d == HOLD);
    select_d = valid_d ? win_d : '0;
    grant_d  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_d[k] = valid_d && (win_d == SELECT_WIDTH'(k));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cred_q   <= '0;
      grant_q  <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cred_q   <= cred_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.select = select_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_arbiter_rr_weighted.sv
// Bench for arbiter_rr_weighted: directed scenarios plus random traffic
// checked cycle by cycle against a tenure-level reference model.
module tb_arbiter_rr_weighted;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int WW = 4;

  logic ap_clk = 1'b0;
  logic areset;

  always #5 ap_clk = ~ap_clk;

  arbiter_rr_weighted_if #(
    .NUM_REQ(N), .SELECT_WIDTH(SW), .WEIGHT_WIDTH(WW)
  ) bus ();

  arbiter_rr_weighted #(
    .NUM_REQ(N), .SELECT_WIDTH(SW), .WEIGHT_WIDTH(WW)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: current holder (-1 = none), credits left, rr pointer
  int m_hold = -1;
  int m_cred = 0;
  int m_ptr  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int w;
    if (areset) begin
      m_hold = -1;
      m_ptr  = 0;
      m_cred = 0;
    end else if (m_hold < 0) begin
      if (bus.enable && bus.req != '0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (bus.req[c]) begin
            m_hold = c;
            break;
          end
        end
`ifdef ARBITER_RR_WEIGHTED_EN
        w = int'(bus.weight[m_hold*WW +: WW]);
        m_cred = (w == 0) ? 1 : w;
`else
        w = 0;
        m_cred = 1 + w;
`endif
      end
    end else begin
      if (!bus.req[m_hold]) begin
        m_ptr  = (m_hold + 1) % N;
        m_hold = -1;
      end else if (bus.ready_in && bus.req_last[m_hold]) begin
        m_cred--;
        if (m_cred == 0) begin
          m_ptr  = (m_hold + 1) % N;
          m_hold = -1;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0]  eg;
    logic [SW-1:0] es;
    @(posedge ap_clk);
    model_edge();
    #1;
    eg = (m_hold >= 0) ? (N'(1) << m_hold) : '0;
    es = (m_hold >= 0) ? SW'(m_hold) : '0;
    check("grant", 64'(bus.grant), 64'(eg));
    check("select", 64'(bus.select), 64'(es));
    check("valid", 64'(bus.valid), 64'(m_hold >= 0));
    check("onehot", 64'($onehot0(bus.grant)), 64'(1));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    check("rst_grant", 64'(bus.grant), 64'(0));
    check("rst_valid", 64'(bus.valid), 64'(0));
    check("rst_select", 64'(bus.select), 64'(0));
    areset = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int t;
    t = 0;
    while (!bus.valid && t < budget) begin
      step();
      t++;
    end
    check("wait_valid", 64'(bus.valid), 64'(1));
  endtask

  task automatic tenure(output int idx, output int len);
    int t;
    wait_valid(20);
    idx = int'(bus.select);
    len = 0;
    t   = 0;
    while (bus.valid && t < 50) begin
      len++;
      step();
      t++;
    end
    check("tenure_end", 64'(bus.valid), 64'(0));
  endtask

  int idx;
  int len;
  int exp_rot[5] = '{0, 1, 2, 3, 0};
`ifdef ARBITER_RR_WEIGHTED_EN
  int exp_len0 = 3;
`else
  int exp_len0 = 1;
`endif

  initial begin
    areset       = 1'b1;
    bus.enable   = 1'b1;
    bus.req      = '0;
    bus.req_last = '0;
    bus.weight   = '0;
    bus.ready_in = 1'b0;
    do_reset();

    // rotation with unit weights
    bus.req      = 4'b1111;
    bus.req_last = 4'b1111;
    bus.weight   = 16'h1111;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tenure(idx, len);
      check("rot_idx", 64'(idx), 64'(exp_rot[i]));
      check("rot_len", 64'(len), 64'(1));
    end

    // weight 3 on requester 0
    bus.req = '0;
    do_reset();
    bus.req    = 4'b0011;
    bus.weight = 16'h1113;
    tenure(idx, len);
    check("w3_idx0", 64'(idx), 64'(0));
    check("w3_len0", 64'(len), 64'(exp_len0));
    tenure(idx, len);
    check("w3_idx1", 64'(idx), 64'(1));
    check("w3_len1", 64'(len), 64'(1));
    tenure(idx, len);
    check("w3_idx2", 64'(idx), 64'(0));
    check("w3_len2", 64'(len), 64'(exp_len0));

    // backpressure on requester 2
    bus.req = '0;
    do_reset();
    bus.weight   = 16'h1111;
    bus.req      = 4'b0100;
    bus.req_last = 4'b0100;
    bus.ready_in = 1'b0;
    wait_valid(20);
    check("bp_sel", 64'(bus.select), 64'(2));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", 64'(bus.grant), 64'(4'b0100));
    end
    bus.ready_in = 1'b1;
    step();
    check("bp_rel", 64'(bus.valid), 64'(0));

    // abort by requester 1, pending 3 and 0
    bus.req = '0;
    do_reset();
    bus.ready_in = 1'b0;
    bus.req      = 4'b1010;
    wait_valid(20);
    check("ab_sel1", 64'(bus.select), 64'(1));
    bus.req = 4'b1001;
    step();
    check("ab_drop", 64'(bus.valid), 64'(0));
    step();
    check("ab_valid3", 64'(bus.valid), 64'(1));
    check("ab_sel3", 64'(bus.select), 64'(3));

    // reset during hold of requester 3
    bus.req = '0;
    do_reset();
    bus.req = 4'b1000;
    wait_valid(20);
    check("rh_sel3", 64'(bus.select), 64'(3));
    areset  = 1'b1;
    bus.req = 4'b1111;
    step();
    check("rh_valid", 64'(bus.valid), 64'(0));
    check("rh_grant", 64'(bus.grant), 64'(0));
    areset = 1'b0;
    step();
    check("rh_first", 64'(bus.select), 64'(0));
    check("rh_fvalid", 64'(bus.valid), 64'(1));

    // zero weight on requester 1
    bus.req = '0;
    do_reset();
    bus.weight   = 16'h1101;
    bus.req      = 4'b0010;
    bus.req_last = 4'b1111;
    bus.ready_in = 1'b1;
    tenure(idx, len);
    check("w0_idx", 64'(idx), 64'(1));
    check("w0_len", 64'(len), 64'(1));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      areset       = ($urandom_range(0, 199) == 0);
      bus.enable   = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < N; b++) begin
        bus.req[b]      = ($urandom_range(0, 9) < 7);
        bus.req_last[b] = $urandom_range(0, 1) == 1;
      end
      bus.weight   = WW*N'($urandom);
      bus.ready_in = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_weighted.md
ARBITER_RR_WEIGHTED -- requirements
Module: arbiter_rr_weighted

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; legal values 2..64.
REQ-002 SHALL have parameter SELECT_WIDTH, default $clog2(NUM_REQ), width of the select index.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4, width of each per-requester weight.
REQ-004 ap_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 areset  input  1  reset; synchronous, active-high.
REQ-006 enable  input  1  permits new arbitration; does not break an existing grant.
REQ-007 req  input  NUM_REQ  per-requester request, level-sensitive.
REQ-008 req_last  input  NUM_REQ  marks the final beat of the winner's current transaction.
REQ-009 weight  input  NUM_REQ*WEIGHT_WIDTH  transactions per grant tenure; requester i uses bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-010 ready_in  input  1  downstream accepts the current beat.
REQ-011 grant  output  NUM_REQ  one-hot registered grant.
REQ-012 select  output  SELECT_WIDTH  binary index of the granted requester.
REQ-013 valid  output  1  a grant is held.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-015 In IDLE with enable=1 and any req bit set, SHALL pick the first set req at or above rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 On that pick, SHALL enter HOLD, drive grant/select/valid from the next cycle (1-cycle latency), and load credit with weight[winner].
REQ-017 SHALL treat a weight of 0 as 1.
REQ-018 A beat SHALL be a cycle in HOLD with req[winner]=1 and ready_in=1.
REQ-019 A beat with req_last[winner]=1 SHALL decrement credit by 1.
REQ-020 SHALL leave HOLD for IDLE when a last beat brings credit to 0.
REQ-021 SHALL leave HOLD for IDLE when req[winner]=0 (abort); credit is discarded.
REQ-022 On leaving HOLD, SHALL set rr_ptr to winner+1 modulo NUM_REQ and drive grant=0, valid=0 for exactly one cycle before the next grant.
REQ-023 enable=0 during HOLD SHALL NOT affect the tenure; enable=0 in IDLE SHALL hold the FSM in IDLE with outputs 0.
REQ-024 req, req_last and weight bits of non-winners SHALL be ignored during HOLD.
REQ-025 grant SHALL be zero or one-hot at all times, and select SHALL equal the index of its set bit whenever valid=1.
REQ-026 weight SHALL be sampled only at grant time; changes during HOLD SHALL have no effect.

Reset
REQ-027 While areset=1: FSM=IDLE, rr_ptr=0, credit=0, grant=0, select=0, valid=0.
REQ-028 areset asserted during HOLD SHALL drop the grant on the next edge with no release cycle; the first arbitration after reset SHALL start from index 0.

Configuration
REQ-029 Macro ARBITER_RR_WEIGHTED_EN defined: weighted credits per REQ-016..REQ-020.
REQ-030 Macro ARBITER_RR_WEIGHTED_EN undefined: credit is fixed at 1, the weight port remains present but is ignored, and each tenure ends after one last beat; all other behaviour is unchanged.

Verification
REQ-031 req=4'b1111, all weights 1, req_last on every beat, ready_in=1 -> grants rotate 0,1,2,3,0, with one idle cycle between grants.
REQ-032 req=4'b0011, weight[0]=3, macro defined, 1-beat transactions -> requester 0 holds for 3 transactions, then requester 1 is granted; macro undefined -> grants alternate 0,1 every transaction.
REQ-033 Winner 2 granted, ready_in=0 for 5 cycles -> grant=4'b0100 is held with no credit change; release follows the first accepted last beat.
REQ-034 Winner 1 drops req mid-transaction -> valid=0 on the next cycle, rr_ptr=2, and a pending req[3] is granted next.
REQ-035 areset pulsed during HOLD of requester 3 -> outputs are 0 the next cycle; with req=4'b1111, the first grant after reset is requester 0.
REQ-036 weight[1]=0 with req=4'b0010 -> requester 1 is released after exactly one transaction; throughout the test, grant is never multi-hot.
